alarm_ctrl: RTL

//  Alarm stage downstream of the BCD time counters. Consumes the six live BCD time digits and

---
 rtl/alarm_ctrl.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/alarm_ctrl.sv
`timescale 1ns/1ps
// alarm_ctrl: user-settable HH:MM alarm stage that watches the live BCD time,
// rings a beeping buzzer, and supports snooze, dismiss and auto-dismiss.
module alarm_ctrl #(
  parameter int DEBOUNCE_CYC = 500000,
  parameter int SNOOZE_MIN   = 5,
  parameter int RING_SEC     = 60,
  parameter int RST_ALM_H    = 7,
  parameter int RST_ALM_M    = 0
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic [3:0] bcd_h1,
  input  logic [3:0] bcd_h0,
  input  logic [3:0] bcd_m1,
  input  logic [3:0] bcd_m0,
  input  logic [3:0] bcd_s1,
  input  logic [3:0] bcd_s0,
  input  logic       btn_mode,
  input  logic       btn_inc_h,
  input  logic       btn_inc_m,
  input  logic       sw_arm,
  output logic [3:0] alm_h1,
  output logic [3:0] alm_h0,
  output logic [3:0] alm_m1,
  output logic [3:0] alm_m0,
  output logic       set_mode,
  output logic       ringing,
  output logic       buzzer
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam int RING_W = $clog2(RING_SEC + 1);
  localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [RING_W-1:0] RING_LAST   = RING_W'(RING_SEC - 1);
  localparam logic [11:0]       SNOOZE_LOAD = 12'(SNOOZE_MIN * 60);
  localparam logic [3:0] RST_H1 = 4'(RST_ALM_H / 10);
  localparam logic [3:0] RST_H0 = 4'(RST_ALM_H % 10);
  localparam logic [3:0] RST_M1 = 4'(RST_ALM_M / 10);
  localparam logic [3:0] RST_M0 = 4'(RST_ALM_M % 10);

  typedef enum logic [1:0] {IDLE, SET, RING, SNOOZE} state_t;

  state_t state_q, state_d;

  logic [2:0]      btn_raw, btn_s1, btn_s2, btn_lvl, btn_press;
  logic [DB_W-1:0] db_cnt [3];
  logic            press_mode, press_inc_h, press_inc_m;

  logic tick_s1, tick_s2, tick_s3, tick;
  logic arm_s1, arm;
  logic match, match_q, trigger;

  logic [RING_W-1:0] ring_cnt;
  logic [11:0]       snooze_cnt;

  logic beep_q, beep_d;
  logic set_mode_d, ringing_d, buzzer_d;

  logic [3:0] hour_h1, hour_h0, min_m1, min_m0;

  assign btn_raw     = {btn_mode, btn_inc_h, btn_inc_m};
  assign press_mode  = btn_press[2];
  assign press_inc_h = btn_press[1];
  assign press_inc_m = btn_press[0];

  assign tick    = tick_s2 & ~tick_s3;
  assign match   = ({bcd_h1, bcd_h0, bcd_m1, bcd_m0} == {alm_h1, alm_h0, alm_m1, alm_m0})
                   && (bcd_s1 == 4'd0) && (bcd_s0 == 4'd0);
  assign trigger = match & ~match_q;

  // Synchronise the buttons and accept a new level only after it has been stable long enough; pulse on each accepted press
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      btn_s1    <= '0;
      btn_s2    <= '0;
      btn_lvl   <= '0;
      btn_press <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      btn_s1 <= btn_raw;
      btn_s2 <= btn_s1;
      for (int i = 0; i < 3; i++) begin
        btn_press[i] <= 1'b0;
        if (btn_s2[i] == btn_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          btn_lvl[i]   <= btn_s2[i];
          db_cnt[i]    <= '0;
          btn_press[i] <= btn_s2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Synchronise the 1 Hz tick and arm switch, and remember last cycle's match so the alarm fires only on its rising edge
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      tick_s1 <= 1'b0;
      tick_s2 <= 1'b0;
      tick_s3 <= 1'b0;
      arm_s1  <= 1'b0;
      arm     <= 1'b0;
      match_q <= 1'b0;
    end else begin
      tick_s1 <= tick_1hz;
      tick_s2 <= tick_s1;
      tick_s3 <= tick_s2;
      arm_s1  <= sw_arm;
      arm     <= arm_s1;
      match_q <= match;
    end
  end

  // State register
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; a MODE press always wins over INC presses in the same cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (press_mode)         state_d = SET;
        else if (trigger & arm) state_d = RING;
      end
      SET: begin
        if (press_mode) state_d = IDLE;
      end
      RING: begin
        if (press_mode || !arm)                state_d = IDLE;
        else if (press_inc_h || press_inc_m)   state_d = SNOOZE;
        else if (tick && ring_cnt == RING_LAST) state_d = IDLE;
      end
      SNOOZE: begin
        if (press_mode || !arm)                    state_d = IDLE;
        else if (tick && snooze_cnt <= 12'd1)      state_d = RING;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs line up with the state register
  always_comb begin
    set_mode_d = (state_d == SET);
    ringing_d  = (state_d == RING);
    beep_d     = beep_q;
    if (state_d == RING && state_q != RING) beep_d = 1'b1;
    else if (state_q == RING && tick)       beep_d = ~beep_q;
    buzzer_d   = beep_d & ringing_d;
  end

  // Registered status and buzzer outputs
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      set_mode <= 1'b0;
      ringing  <= 1'b0;
      buzzer   <= 1'b0;
      beep_q   <= 1'b0;
    end else begin
      set_mode <= set_mode_d;
      ringing  <= ringing_d;
      buzzer   <= buzzer_d;
      beep_q   <= beep_d;
    end
  end

  // Ring-timeout counter restarts on every entry to RING; snooze counter loads on RING->SNOOZE and counts ticks down
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      ring_cnt   <= '0;
      snooze_cnt <= '0;
    end else begin
      if (state_d == RING && state_q != RING) ring_cnt <= '0;
      else if (state_q == RING && tick)       ring_cnt <= ring_cnt + RING_W'(1);
      if (state_q == RING && state_d == SNOOZE)
        snooze_cnt <= SNOOZE_LOAD;
      else if (state_q == SNOOZE && tick && snooze_cnt != 12'd0)
        snooze_cnt <= snooze_cnt - 12'd1;
    end
  end

  // BCD increment of the alarm hour (23 wraps to 00) and minute (59 wraps to 00, never carrying into the hour)
  always_comb begin
    hour_h1 = alm_h1;
    hour_h0 = alm_h0;
    min_m1  = alm_m1;
    min_m0  = alm_m0;
    if (alm_h1 == 4'd2 && alm_h0 == 4'd3) begin
      hour_h1 = 4'd0;
      hour_h0 = 4'd0;
    end else if (alm_h0 == 4'd9) begin
      hour_h1 = alm_h1 + 4'd1;
      hour_h0 = 4'd0;
    end else begin
      hour_h0 = alm_h0 + 4'd1;
    end
    if (alm_m0 == 4'd9) begin
      min_m0 = 4'd0;
      min_m1 = (alm_m1 == 4'd5) ? 4'd0 : alm_m1 + 4'd1;
    end else begin
      min_m0 = alm_m0 + 4'd1;
    end
  end

  // Alarm time register, edited only in SET; hour and minute presses in one cycle are both applied
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      alm_h1 <= RST_H1;
      alm_h0 <= RST_H0;
      alm_m1 <= RST_M1;
      alm_m0 <= RST_M0;
    end else if (state_q == SET && !press_mode) begin
      if (press_inc_h) begin
        alm_h1 <= hour_h1;
        alm_h0 <= hour_h0;
      end
      if (press_inc_m) begin
        alm_m1 <= min_m1;
        alm_m0 <= min_m0;
      end
    end
  end

endmodule
